// File: rtl/dir_rom_scan_arb.sv
// rtl/dir_rom_scan_arb.sv - round-robin job arbiter and direction-bin ROM scanner
//
// Two descriptor units request jobs. Each job carries an orientation offset.
// One job is granted at a time. All 2^ADDR_W ROM entries are scanned in
// address order. Each bin is rotated by the offset (mod 2^BIN_W) and streamed
// out on a valid/ready interface.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req[1:0]              level job requests, held until ack
//   req_ori0, req_ori1    orientation offsets, sampled at grant
//   ack[1:0]              one-cycle pulse, job accepted for requester i
//   done[1:0]             one-cycle pulse, last entry of requester i's job accepted
//   rom_a / rom_spo       external combinational ROM address / data
//   out_valid/out_ready   output handshake
//   out_bin, out_idx      rotated bin and its ROM address
//   out_last, out_src     last entry of job, owning requester
//   busy                  job in progress (SCAN or DRAIN)
module dir_rom_scan_arb #(
   parameter int ADDR_W = 8,
   parameter int BIN_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        req,
   input  logic [BIN_W-1:0]  req_ori0,
   input  logic [BIN_W-1:0]  req_ori1,
   output logic [1:0]        ack,
   output logic [1:0]        done,
   output logic [ADDR_W-1:0] rom_a,
   input  logic [BIN_W-1:0]  rom_spo,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BIN_W-1:0]  out_bin,
   output logic [ADDR_W-1:0] out_idx,
   output logic              out_last,
   output logic              out_src,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic [BIN_W-1:0]  ori_q;
   logic              src_q;
   logic              last_src_q;
   logic [1:0]        ack_q;
   logic [1:0]        done_q;
   logic              out_valid_q;
   logic              out_last_q;
   logic              busy_q;
   logic [BIN_W-1:0]  out_bin_q;
   logic [ADDR_W-1:0] out_idx_q;

   logic              gnt_src_d;
   logic              load;
   logic              cnt_max;

   // Both requesting: alternate away from the last served requester.
   always_comb begin
      gnt_src_d = 1'b0;
      if (req == 2'b11) begin
         gnt_src_d = ~last_src_q;
      end else begin
         gnt_src_d = req[1];
      end
   end

   // The output register can take a new entry when empty or being drained.
   assign load    = !out_valid_q || out_ready;
   assign cnt_max = &cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         ori_q       <= '0;
         src_q       <= 1'b0;
         last_src_q  <= 1'b1;
         ack_q       <= '0;
         done_q      <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         out_bin_q   <= '0;
         out_idx_q   <= '0;
      end else begin
         ack_q  <= '0;
         done_q <= '0;
         case (state_q)
            IDLE: begin
               if (|req) begin
                  src_q      <= gnt_src_d;
                  last_src_q <= gnt_src_d;
                  ori_q      <= gnt_src_d ? req_ori1 : req_ori0;
                  cnt_q      <= '0;
                  busy_q     <= 1'b1;
                  ack_q      <= gnt_src_d ? 2'b10 : 2'b01;
                  state_q    <= SCAN;
               end
            end
            SCAN: begin
               if (load) begin
                  out_bin_q   <= rom_spo + ori_q;
                  out_idx_q   <= cnt_q;
                  out_last_q  <= cnt_max;
                  out_valid_q <= 1'b1;
                  cnt_q       <= cnt_q + 1'b1;
                  if (cnt_max) begin
                     state_q <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (out_valid_q && out_ready) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  busy_q      <= 1'b0;
                  done_q      <= src_q ? 2'b10 : 2'b01;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Address is only driven while scanning so reset forces it to zero at once.
   assign rom_a     = (state_q == SCAN) ? cnt_q : '0;
   assign ack       = ack_q;
   assign done      = done_q;
   assign out_valid = out_valid_q;
   assign out_bin   = out_bin_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;
   assign out_src   = src_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_dir_rom_scan_arb.sv
// tb/tb_dir_rom_scan_arb.sv - self-checking bench for dir_rom_scan_arb
module tb_dir_rom_scan_arb;
   localparam int N = 256;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] req = 2'b00;
   logic [4:0] req_ori0 = 5'd0;
   logic [4:0] req_ori1 = 5'd0;
   logic [1:0] ack;
   logic [1:0] done;
   logic [7:0] rom_a;
   logic [4:0] rom_spo;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [4:0] out_bin;
   logic [7:0] out_idx;
   logic       out_last;
   logic       out_src;
   logic       busy;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   dir_rom_scan_arb #(.ADDR_W(8), .BIN_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_ori0(req_ori0), .req_ori1(req_ori1),
      .ack(ack), .done(done), .rom_a(rom_a), .rom_spo(rom_spo),
      .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin), .out_idx(out_idx),
      .out_last(out_last), .out_src(out_src), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [4:0] rom_f(input logic [7:0] a);
      case (a)
         8'd0:    return 5'h1d;
         8'd3:    return 5'h00;
         8'd16:   return 5'h1d;
         8'd240:  return 5'h16;
         8'd255:  return 5'h03;
         default: return 5'((a * 8'd13) ^ (a >> 3));
      endcase
   endfunction

   assign rom_spo = rom_f(rom_a);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
   endtask

   // Reference model: a job is (owner, offset, cycles since grant, beats accepted).
   // Entry n is on the output once two cycles have passed since grant and until accepted.
   logic       m_act = 1'b0;
   logic       m_src = 1'b0;
   logic       m_last = 1'b1;
   logic [4:0] m_ori = 5'd0;
   int         m_p = 0;
   int         m_n = 0;
   logic [1:0] m_ack = 2'b00;
   logic [1:0] m_done = 2'b00;

   always @(posedge clk or negedge rst_n) begin
      logic g;
      logic vis;
      int   nn;
      if (!rst_n) begin
         m_act  <= 1'b0;
         m_src  <= 1'b0;
         m_last <= 1'b1;
         m_ori  <= 5'd0;
         m_p    <= 0;
         m_n    <= 0;
         m_ack  <= 2'b00;
         m_done <= 2'b00;
      end else begin
         vis = m_act && (m_p >= 2) && (m_n < N);
         m_ack  <= 2'b00;
         m_done <= 2'b00;
         if (!m_act) begin
            if (req != 2'b00) begin
               g = (req == 2'b11) ? ~m_last : req[1];
               m_act  <= 1'b1;
               m_src  <= g;
               m_last <= g;
               m_ori  <= g ? req_ori1 : req_ori0;
               m_p    <= 1;
               m_n    <= 0;
               m_ack  <= g ? 2'b10 : 2'b01;
            end
         end else begin
            m_p <= m_p + 1;
            nn = m_n + ((vis && out_ready) ? 1 : 0);
            m_n <= nn;
            if (nn == N) begin
               m_act  <= 1'b0;
               m_done <= m_src ? 2'b10 : 2'b01;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic       ev;
      int         er;
      logic [4:0] eb;
      ev = m_act && (m_p >= 2) && (m_n < N);
      er = (m_act && ev && (m_n != N - 1)) ? m_n + 1 : 0;
      eb = rom_f(8'(m_n)) + m_ori;
      chk("ack", 32'(ack), 32'(m_ack));
      chk("done", 32'(done), 32'(m_done));
      chk("busy", 32'(busy), 32'(m_act));
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("rom_a", 32'(rom_a), 32'(er));
      if (ev) begin
         chk("out_idx", 32'(out_idx), 32'(m_n));
         chk("out_bin", 32'(out_bin), 32'(eb));
         chk("out_last", 32'(out_last), 32'(m_n == N - 1));
         chk("out_src", 32'(out_src), 32'(m_src));
      end
   end

   int beats = 0;
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beats <= 0;
      end else if (ack != 2'b00) begin
         beats <= 0;
      end else if (done != 2'b00) begin
         chk("beats_per_job", beats, N);
         beats <= 0;
      end else if (out_valid && out_ready) begin
         beats <= beats + 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(output logic [1:0] a, output int c);
      a = 2'b00;
      c = -1;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (ack != 2'b00) begin
            a = ack;
            c = cyc;
            return;
         end
      end
      timeout_fail("wait_ack");
   endtask

   task automatic wait_done(output logic [1:0] d, output int c);
      d = 2'b00;
      c = -1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (done != 2'b00) begin
            d = done;
            c = cyc;
            return;
         end
      end
      timeout_fail("wait_done");
   endtask

   task automatic wait_idx(input int idx);
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (out_valid && (int'(out_idx) == idx)) return;
      end
      timeout_fail("wait_idx");
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] a, d, a2;
      int         c, c2, t0;
      logic [4:0] held;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rom_a", 32'(rom_a), 0);
      chk("rst_bin", 32'(out_bin), 0);
      chk("rst_idx", 32'(out_idx), 0);
      chk("rst_src", 32'(out_src), 0);
      chk("rst_last", 32'(out_last), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();

      // Job 1: requester 0, offset 0
      req = 2'b01;
      req_ori0 = 5'd0;
      t0 = cyc;
      wait_ack(a, c);
      chk("j1_ack", 32'(a), 32'h1);
      chk("j1_ack_cycle", c, t0 + 1);
      step();
      req = 2'b00;
      wait_idx(0);
      chk("j1_first_cycle", cyc, t0 + 2);
      chk("j1_bin0", 32'(out_bin), 32'h1d);
      wait_idx(3);
      chk("j1_bin3", 32'(out_bin), 32'h00);
      wait_idx(16);
      chk("j1_bin16", 32'(out_bin), 32'h1d);
      wait_idx(255);
      chk("j1_bin255", 32'(out_bin), 32'h03);
      chk("j1_last255", 32'(out_last), 1);
      chk("j1_last_cycle", cyc, t0 + 257);
      wait_done(d, c);
      chk("j1_done", 32'(d), 32'h1);
      chk("j1_done_cycle", c, t0 + 258);

      // Job 2: offset 5 wraps mod 32
      step();
      req = 2'b01;
      req_ori0 = 5'd5;
      wait_ack(a, c);
      step();
      req = 2'b00;
      req_ori0 = 5'd17;
      wait_idx(0);
      chk("j2_bin0", 32'(out_bin), 32'h02);
      wait_idx(240);
      chk("j2_bin240", 32'(out_bin), 32'h1b);
      wait_idx(255);
      chk("j2_bin255", 32'(out_bin), 32'h08);
      wait_done(d, c);

      // Round robin after reset: 0, then 1, then 0 again
      do_reset();
      req = 2'b11;
      req_ori0 = 5'($urandom);
      req_ori1 = 5'($urandom);
      wait_ack(a, c);
      chk("rr_first", 32'(a), 32'h1);
      step();
      req = 2'b10;
      wait_done(d, c2);
      chk("rr_done0", 32'(d), 32'h1);
      wait_ack(a2, c2);
      chk("rr_second", 32'(a2), 32'h2);
      chk("rr_spacing", c2 - c, 258);
      step();
      req = 2'b00;
      wait_done(d, c);
      chk("rr_done1", 32'(d), 32'h2);
      step();
      req = 2'b11;
      wait_ack(a, c);
      chk("rr_third", 32'(a), 32'h1);
      step();
      req = 2'b00;
      wait_done(d, c2);

      // Backpressure: three stall cycles on idx 10
      step();
      req = 2'b01;
      req_ori0 = 5'd7;
      wait_ack(a, t0);
      step();
      req = 2'b00;
      wait_idx(9);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      held = rom_f(8'd10) + 5'd7;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_idx", 32'(out_idx), 10);
         chk("stall_bin", 32'(out_bin), 32'(held));
         chk("stall_valid", 32'(out_valid), 1);
         if (i < 2) step();
      end
      step();
      out_ready = 1'b1;
      @(negedge clk);
      chk("release_idx10", 32'(out_idx), 10);
      step();
      @(negedge clk);
      chk("release_idx11", 32'(out_idx), 11);
      wait_done(d, c);
      chk("stall_done_delay", c - t0, 260);

      // Reset in the middle of a job
      step();
      req = 2'b01;
      wait_ack(a, c);
      step();
      req = 2'b00;
      wait_idx(100);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_valid", 32'(out_valid), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_rom_a", 32'(rom_a), 0);
      chk("abort_idx", 32'(out_idx), 0);
      step();
      step();
      rst_n = 1'b1;
      step();
      req = 2'b10;
      req_ori1 = 5'd3;
      wait_ack(a, c);
      chk("restart_ack", 32'(a), 32'h2);
      step();
      req = 2'b00;
      wait_idx(0);
      chk("restart_bin0", 32'(out_bin), 32'h00);

      // Short req0 pulse during an active job is ignored
      repeat (50) step();
      req = 2'b01;
      step();
      req = 2'b00;
      wait_done(d, c);
      chk("pulse_done_src", 32'(d), 32'h2);
      repeat (5) step();
      @(negedge clk);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_valid", 32'(out_valid), 0);

      // Randomized requests, offsets and backpressure
      for (int i = 0; i < 3000; i++) begin
         step();
         if ($urandom_range(0, 7) == 0) req[0] = ~req[0];
         if ($urandom_range(0, 7) == 0) req[1] = ~req[1];
         req_ori0 = 5'($urandom);
         req_ori1 = 5'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
      end
      step();
      req = 2'b00;
      out_ready = 1'b1;
      begin
         int k;
         k = 0;
         while (busy && k < 1000) begin
            @(negedge clk);
            k++;
         end
         if (busy) timeout_fail("final_drain");
      end
      repeat (3) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
